// File: rtl/button_pkg.sv
// Shared types and default constants for the push-button conditioning block.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_LONG_CYCLES   = 7;

endpackage

// File: rtl/button_debounce_sync2.sv
// Two-flop synchroniser for an asynchronous level input; both flops reset to 0.
module sync2 (
    input  logic CLK,
    input  logic RST_n,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/button_debounce.sv
// Debounced button level plus registered press/release strobes.
// Optional long-press strobe when LONG_PRESS_EN is defined.
module button_debounce
    import button_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = 3,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic i_in,
    output logic o_out,
    output logic o_press,
    output logic o_release,
    output logic o_long_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > (1 << CNT_W) - 1 || LONG_CYCLES < 1) begin : g_param_chk
        $error("button_debounce: STABLE_CYCLES/CNT_W/LONG_CYCLES out of range");
    end

    logic             w_s2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_press;
    logic             r_release;

    sync2 u_sync (
        .CLK   (CLK),
        .RST_n (RST_n),
        .i_d   (i_in),
        .o_q   (w_s2)
    );

    // Counter holds the number of consecutive agreeing samples seen so far in a CHK state
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_out     <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                RELEASED: begin
                    if (w_s2) begin
                        r_state <= PRESS_CHK;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!w_s2) begin
                        r_state <= RELEASED;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                        r_out   <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!w_s2) begin
                        r_state <= RELEASE_CHK;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                RELEASE_CHK: begin
                    if (w_s2) begin
                        r_state   <= PRESSED;
                        r_cnt     <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= RELEASED;
                        r_cnt     <= '0;
                        r_out     <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt     <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= RELEASED;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_out     = r_out;
    assign o_press   = r_press;
    assign o_release = r_release;

`ifdef LONG_PRESS_EN
    localparam int              LONG_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES);

    logic [LONG_W-1:0] r_lcnt;
    logic              r_long;
    logic              w_press_acc;

    assign w_press_acc = (r_state == PRESS_CHK) && w_s2 && (r_cnt == CNT_LAST);

    // Saturation at LONG_LAST is what limits the strobe to once per accepted press
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_lcnt <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (w_press_acc) begin
                r_lcnt <= '0;
            end else if (r_state == PRESSED && r_lcnt != LONG_LAST) begin
                r_lcnt <= r_lcnt + LONG_W'(1);
                if (r_lcnt == LONG_LAST - LONG_W'(1))
                    r_long <= 1'b1;
            end
        end
    end

    assign o_long_press = r_long;
`else
    assign o_long_press = 1'b0;
`endif

endmodule
